// File: rtl/cordic_pkg.sv
`default_nettype none
//============================================================================
// Module  : cordic_pkg
// Brief   : Shared CORDIC constants, mode encoding and fixed-point rescaling.
// Revision: 1.0 - initial release
//============================================================================
package cordic_pkg;

    typedef enum logic {
        CORDIC_ROTATE = 1'b0,
        CORDIC_VECTOR = 1'b1
    } cordic_mode_t;

    // atan(2^-i) in Q.16, rounded to nearest
    localparam int ATAN_Q16 [0:15] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
        256,   128,   64,    32,   16,   8,    4,    2
    };

    localparam int PI_Q16    = 205887;
    localparam int INV_K_Q16 = 39797;

    // Round a Q.16 constant to frac_w fractional bits.
    function automatic int scale_q16(input int value, input int frac_w);
        if (frac_w >= 16) begin
            return value <<< (frac_w - 16);
        end
        return (value + (1 <<< (15 - frac_w))) >>> (16 - frac_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_stage.sv
`default_nettype none
//============================================================================
// Module  : cordic_stage
// Brief   : One registered CORDIC micro-rotation (rotate or vector, per sample).
// Revision: 1.0 - initial release
//============================================================================
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W     = 14,
    parameter int ZW    = 13,
    parameter int SHIFT = 0,
    parameter int ATAN  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_mode,
    input  logic signed [W-1:0]  i_x,
    input  logic signed [W-1:0]  i_y,
    input  logic signed [ZW-1:0] i_z,
    output logic                 o_valid,
    output logic                 o_mode,
    output logic signed [W-1:0]  o_x,
    output logic signed [W-1:0]  o_y,
    output logic signed [ZW-1:0] o_z
);

    localparam logic signed [ZW-1:0] c_ATAN = ZW'(ATAN);

    logic signed [W-1:0]  w_x_sh;
    logic signed [W-1:0]  w_y_sh;
    logic                 w_pos;
    logic                 r_valid;
    logic                 r_mode;
    logic signed [W-1:0]  r_x;
    logic signed [W-1:0]  r_y;
    logic signed [ZW-1:0] r_z;

    assign w_x_sh = i_x >>> SHIFT;
    assign w_y_sh = i_y >>> SHIFT;

    // Direction d=+1: rotate toward z=0, or vector toward y=0 from below
    assign w_pos = (i_mode == CORDIC_VECTOR) ? i_y[W-1] : ~i_z[ZW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_mode <= i_mode;
                if (w_pos) begin
                    r_x <= i_x - w_y_sh;
                    r_y <= i_y + w_x_sh;
                    r_z <= i_z - c_ATAN;
                end else begin
                    r_x <= i_x + w_y_sh;
                    r_y <= i_y - w_x_sh;
                    r_z <= i_z + c_ATAN;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;

endmodule
`default_nettype wire

// File: rtl/cordic_engine.sv
`default_nettype none
//============================================================================
// Module  : cordic_engine
// Brief   : Fully pipelined dual-mode CORDIC (rotate / vector), 1 sample/clock.
// Revision: 1.0 - initial release
//============================================================================
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int FRAC_W    = 8,
    parameter int STAGES    = 10,
    parameter int ID_WIDTH  = 8,
    parameter int GAIN_COMP = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_mode,
    input  logic [DATA_W-1:0]   in_x,
    input  logic [DATA_W-1:0]   in_y,
    input  logic [DATA_W-1:0]   in_angle,
    input  logic [ID_WIDTH-1:0] in_id,
    output logic                out_valid,
    output logic                out_mode,
    output logic [DATA_W-1:0]   out_x,
    output logic [DATA_W-1:0]   out_y,
    output logic [DATA_W-1:0]   out_angle,
    output logic [ID_WIDTH-1:0] out_id
);

    localparam int c_XW = DATA_W + 2;
    localparam int c_ZW = DATA_W + 1;

    localparam logic signed [c_ZW-1:0] c_PI      = c_ZW'(scale_q16(PI_Q16, FRAC_W));
    localparam logic signed [c_ZW-1:0] c_HALF_PI = c_ZW'(scale_q16(PI_Q16, FRAC_W) / 2);
    localparam logic signed [c_XW-1:0] c_XMAX    = c_XW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [c_XW-1:0] c_XMIN    = c_XW'(-(1 << (DATA_W - 1)));
    localparam logic signed [c_ZW-1:0] c_ZMAX    = c_ZW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [c_ZW-1:0] c_ZMIN    = c_ZW'(-(1 << (DATA_W - 1)));
    localparam logic signed [16:0]     c_INV_K   = 17'(INV_K_Q16);

    function automatic logic [DATA_W-1:0] f_sat_xy(input logic signed [c_XW-1:0] v);
        if (v > c_XMAX) return c_XMAX[DATA_W-1:0];
        if (v < c_XMIN) return c_XMIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] f_sat_z(input logic signed [c_ZW-1:0] v);
        if (v > c_ZMAX) return c_ZMAX[DATA_W-1:0];
        if (v < c_ZMIN) return c_ZMIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    logic signed [c_XW-1:0] w_xi;
    logic signed [c_XW-1:0] w_yi;
    logic signed [c_ZW-1:0] w_ai;
    logic signed [c_ZW-1:0] w_ac;
    logic signed [c_XW-1:0] w_px;
    logic signed [c_XW-1:0] w_py;
    logic signed [c_ZW-1:0] w_pz;
    logic                   w_zero;

    assign w_xi = {{2{in_x[DATA_W-1]}}, in_x};
    assign w_yi = {{2{in_y[DATA_W-1]}}, in_y};
    assign w_ai = {in_angle[DATA_W-1], in_angle};

    // Quadrant pre-rotation brings every input into the +/-pi/2 convergence range
    always_comb begin
        w_ac   = w_ai;
        w_px   = w_xi;
        w_py   = w_yi;
        w_pz   = '0;
        w_zero = 1'b0;
        if (w_ai > c_PI) begin
            w_ac = c_PI;
        end else if (w_ai < -c_PI) begin
            w_ac = -c_PI;
        end
        if (in_mode == CORDIC_ROTATE) begin
            w_pz = w_ac;
            if (w_ac > c_HALF_PI) begin
                w_px = -w_yi;
                w_py = w_xi;
                w_pz = w_ac - c_HALF_PI;
            end else if (w_ac < -c_HALF_PI) begin
                w_px = w_yi;
                w_py = -w_xi;
                w_pz = w_ac + c_HALF_PI;
            end
        end else begin
            w_zero = (w_xi == '0) && (w_yi == '0);
            if (w_xi[c_XW-1]) begin
                if (!w_yi[c_XW-1]) begin
                    w_px = w_yi;
                    w_py = -w_xi;
                    w_pz = c_HALF_PI;
                end else begin
                    w_px = -w_yi;
                    w_py = w_xi;
                    w_pz = -c_HALF_PI;
                end
            end
        end
    end

    logic                   w_v [0:STAGES];
    logic                   w_m [0:STAGES];
    logic signed [c_XW-1:0] w_x [0:STAGES];
    logic signed [c_XW-1:0] w_y [0:STAGES];
    logic signed [c_ZW-1:0] w_z [0:STAGES];

    logic                   r_s0_valid;
    logic                   r_s0_mode;
    logic signed [c_XW-1:0] r_s0_x;
    logic signed [c_XW-1:0] r_s0_y;
    logic signed [c_ZW-1:0] r_s0_z;
    logic [ID_WIDTH-1:0]    r_id   [0:STAGES];
    logic                   r_zero [0:STAGES];

    // Input register plus id/zero sideband, which only advance behind a valid
    // sample so that a bubble keeps the tag of the sample ahead of it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s0_mode  <= 1'b0;
            r_s0_x     <= '0;
            r_s0_y     <= '0;
            r_s0_z     <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                r_id[k]   <= '0;
                r_zero[k] <= 1'b0;
            end
        end else begin
            r_s0_valid <= in_valid;
            if (in_valid) begin
                r_s0_mode <= in_mode;
                r_s0_x    <= w_px;
                r_s0_y    <= w_py;
                r_s0_z    <= w_pz;
                r_id[0]   <= in_id;
                r_zero[0] <= w_zero;
            end
            for (int k = 1; k <= STAGES; k++) begin
                if (w_v[k-1]) begin
                    r_id[k]   <= r_id[k-1];
                    r_zero[k] <= r_zero[k-1];
                end
            end
        end
    end

    assign w_v[0] = r_s0_valid;
    assign w_m[0] = r_s0_mode;
    assign w_x[0] = r_s0_x;
    assign w_y[0] = r_s0_y;
    assign w_z[0] = r_s0_z;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        cordic_stage #(
            .W     (c_XW),
            .ZW    (c_ZW),
            .SHIFT (gi),
            .ATAN  (scale_q16(ATAN_Q16[gi], FRAC_W))
        ) u_stage (
            .clk     (clock),
            .rst     (reset),
            .i_valid (w_v[gi]),
            .i_mode  (w_m[gi]),
            .i_x     (w_x[gi]),
            .i_y     (w_y[gi]),
            .i_z     (w_z[gi]),
            .o_valid (w_v[gi+1]),
            .o_mode  (w_m[gi+1]),
            .o_x     (w_x[gi+1]),
            .o_y     (w_y[gi+1]),
            .o_z     (w_z[gi+1])
        );
    end

    logic                   w_f_valid;
    logic                   w_f_mode;
    logic signed [c_XW-1:0] w_f_x;
    logic signed [c_XW-1:0] w_f_y;
    logic signed [c_ZW-1:0] w_f_z;
    logic [ID_WIDTH-1:0]    w_f_id;
    logic                   w_f_zero;

    if (GAIN_COMP != 0) begin : g_gain
        logic signed [c_XW+16:0] w_gx;
        logic signed [c_XW+16:0] w_gy;
        logic                    r_g_valid;
        logic                    r_g_mode;
        logic signed [c_XW-1:0]  r_g_x;
        logic signed [c_XW-1:0]  r_g_y;
        logic signed [c_ZW-1:0]  r_g_z;
        logic [ID_WIDTH-1:0]     r_g_id;
        logic                    r_g_zero;

        // 1/K in Q0.16; the product is floored back to integer scale
        assign w_gx = (c_XW+17)'(w_x[STAGES]) * (c_XW+17)'(c_INV_K);
        assign w_gy = (c_XW+17)'(w_y[STAGES]) * (c_XW+17)'(c_INV_K);

        always_ff @(posedge clock) begin
            if (reset) begin
                r_g_valid <= 1'b0;
                r_g_mode  <= 1'b0;
                r_g_x     <= '0;
                r_g_y     <= '0;
                r_g_z     <= '0;
                r_g_id    <= '0;
                r_g_zero  <= 1'b0;
            end else begin
                r_g_valid <= w_v[STAGES];
                if (w_v[STAGES]) begin
                    r_g_mode <= w_m[STAGES];
                    r_g_x    <= c_XW'(w_gx >>> 16);
                    r_g_y    <= c_XW'(w_gy >>> 16);
                    r_g_z    <= w_z[STAGES];
                    r_g_id   <= r_id[STAGES];
                    r_g_zero <= r_zero[STAGES];
                end
            end
        end

        assign w_f_valid = r_g_valid;
        assign w_f_mode  = r_g_mode;
        assign w_f_x     = r_g_x;
        assign w_f_y     = r_g_y;
        assign w_f_z     = r_g_z;
        assign w_f_id    = r_g_id;
        assign w_f_zero  = r_g_zero;
    end else begin : g_no_gain
        assign w_f_valid = w_v[STAGES];
        assign w_f_mode  = w_m[STAGES];
        assign w_f_x     = w_x[STAGES];
        assign w_f_y     = w_y[STAGES];
        assign w_f_z     = w_z[STAGES];
        assign w_f_id    = r_id[STAGES];
        assign w_f_zero  = r_zero[STAGES];
    end

    assign out_valid = w_f_valid;
    assign out_mode  = w_f_mode;
    assign out_id    = w_f_id;
    assign out_x     = w_f_zero ? '0 : f_sat_xy(w_f_x);
    assign out_y     = f_sat_xy(w_f_y);
    assign out_angle = w_f_zero ? '0 : f_sat_z(w_f_z);

endmodule
`default_nettype wire

// File: tb/tb_cordic_engine.sv
`default_nettype none
//============================================================================
// Module  : tb_cordic_engine
// Brief   : Directed-vector bench for cordic_engine (plain and gain-compensated).
// Revision: 1.0 - initial release
//============================================================================
module tb_cordic_engine;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_mode;
    logic [11:0] in_x;
    logic [11:0] in_y;
    logic [11:0] in_angle;
    logic [7:0]  in_id;

    logic        o0_valid, o0_mode;
    logic [11:0] o0_x, o0_y, o0_angle;
    logic [7:0]  o0_id;
    logic        o1_valid, o1_mode;
    logic [11:0] o1_x, o1_y, o1_angle;
    logic [7:0]  o1_id;

    int n_vec = 0;
    int n_err = 0;

    int rx0, ry0, ra0, rid0, rm0, lat0;
    int rx1, ry1, lat1;

    cordic_engine #(.GAIN_COMP(0)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .in_id(in_id),
        .out_valid(o0_valid), .out_mode(o0_mode), .out_x(o0_x), .out_y(o0_y),
        .out_angle(o0_angle), .out_id(o0_id)
    );

    cordic_engine #(.GAIN_COMP(1)) dut_gc (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .in_id(in_id),
        .out_valid(o1_valid), .out_mode(o1_mode), .out_x(o1_x), .out_y(o1_y),
        .out_angle(o1_angle), .out_id(o1_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int diff;
        n_vec++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic drive(input logic v, input logic mode, input int x, input int y,
                         input int a, input int id);
        in_valid = v;
        in_mode  = mode;
        in_x     = 12'(x);
        in_y     = 12'(y);
        in_angle = 12'(a);
        in_id    = 8'(id);
    endtask

    // One isolated sample; waits (bounded) for it on both instances.
    task automatic run_one(input logic mode, input int x, input int y, input int a, input int id);
        bit got0, got1;
        got0 = 0; got1 = 0;
        lat0 = -1; lat1 = -1;
        rx0 = -9999; ry0 = -9999; ra0 = -9999; rid0 = -1; rm0 = -1;
        rx1 = -9999; ry1 = -9999;
        drive(1'b1, mode, x, y, a, id);
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 40 && !(got0 && got1); c++) begin
            if (!got0 && o0_valid) begin
                got0 = 1; lat0 = c;
                rx0 = $signed(o0_x); ry0 = $signed(o0_y); ra0 = $signed(o0_angle);
                rid0 = int'(o0_id); rm0 = int'(o0_mode);
            end
            if (!got1 && o1_valid) begin
                got1 = 1; lat1 = c;
                rx1 = $signed(o1_x); ry1 = $signed(o1_y);
            end
            if (!(got0 && got1)) begin
                @(posedge clock); #1;
            end
        end
    endtask

    logic sv_valid [0:12];
    int   sv_id    [0:12];
    logic ov  [1:30];
    int   oid [1:30];
    int   om  [1:30];
    int   oa  [1:30];

    initial begin
        int nvalid;
        reset = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", int'(o0_valid), 0, 0);
        check("rst_x", int'(o0_x), 0, 0);
        check("rst_angle", int'(o0_angle), 0, 0);
        check("rst_id", int'(o0_id), 0, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Rotate by pi
        run_one(1'b0, 256, 0, 804, 7);
        check("rot_pi_x", rx0, -422, 4);
        check("rot_pi_y", ry0, 0, 4);
        check("rot_pi_lat", lat0, 11, 0);
        check("rot_pi_id", rid0, 7, 0);
        check("rot_pi_mode", rm0, 0, 0);

        // Rotate by pi/4, with and without gain compensation
        run_one(1'b0, 256, 0, 201, 8);
        check("rot_q_x", rx0, 298, 4);
        check("rot_q_y", ry0, 298, 4);
        check("gc_q_x", rx1, 181, 4);
        check("gc_q_y", ry1, 181, 4);
        check("gc_lat", lat1, 12, 0);

        // Rotate by -pi/2 (boundary of pre-rotation)
        run_one(1'b0, 256, 0, -402, 9);
        check("rot_m90_x", rx0, 0, 4);
        check("rot_m90_y", ry0, -422, 4);

        // Vectoring
        run_one(1'b1, 0, 256, 0, 10);
        check("vec_90_mag", rx0, 422, 4);
        check("vec_90_ang", ra0, 402, 3);
        check("vec_90_mode", rm0, 1, 0);
        run_one(1'b1, -256, -256, 0, 11);
        check("vec_q3_mag", rx0, 596, 4);
        check("vec_q3_ang", ra0, -603, 3);
        run_one(1'b1, 0, 0, 0, 12);
        check("vec_zero_mag", rx0, 0, 0);
        check("vec_zero_ang", ra0, 0, 0);

        // Saturation
        run_one(1'b0, 2047, 2047, 0, 13);
        check("sat_x", rx0, 2047, 0);
        check("sat_y", ry0, 2047, 0);

        // Back-to-back mixed-mode stream with one bubble at slot 6
        for (int s = 0; s <= 12; s++) begin
            sv_valid[s] = (s != 6);
            sv_id[s]    = (s < 6) ? s + 1 : s;
        end
        for (int e = 1; e <= 30; e++) begin
            int s;
            s = e - 1;
            if (s <= 12 && sv_valid[s]) begin
                if (sv_id[s] % 2 == 0) drive(1'b1, 1'b1, 0, 256, 0, sv_id[s]);
                else                   drive(1'b1, 1'b0, 256, 0, 201, sv_id[s]);
            end else begin
                drive(1'b0, 1'b0, 0, 0, 0, 0);
            end
            @(posedge clock); #1;
            ov[e]  = o0_valid;
            oid[e] = int'(o0_id);
            om[e]  = int'(o0_mode);
            oa[e]  = $signed(o0_angle);
        end
        nvalid = 0;
        for (int e = 1; e <= 30; e++) if (ov[e]) nvalid++;
        check("strm_count", nvalid, 12, 0);
        for (int s = 0; s <= 12; s++) begin
            check("strm_valid", int'(ov[s+11]), int'(sv_valid[s]), 0);
            if (sv_valid[s]) begin
                check("strm_id", oid[s+11], sv_id[s], 0);
                check("strm_mode", om[s+11], (sv_id[s] % 2 == 0) ? 1 : 0, 0);
                if (sv_id[s] % 2 == 0) check("strm_vec_ang", oa[s+11], 402, 3);
                else                   check("strm_rot_res", oa[s+11], 0, 4);
            end else begin
                check("strm_bubble_id", oid[s+11], sv_id[s-1], 0);
            end
        end

        // Reset with five samples in flight; new sample the cycle after
        nvalid = 0;
        for (int e = 1; e <= 20; e++) begin
            int s;
            s = e - 1;
            reset = 1'b0;
            if (s < 5)       drive(1'b1, 1'b0, 256, 0, 201, 50 + s);
            else if (s == 6) drive(1'b1, 1'b1, 0, 256, 0, 99);
            else             drive(1'b0, 1'b0, 0, 0, 0, 0);
            if (s == 5) reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            if (e == 6) begin
                check("mrst_x", int'(o0_x), 0, 0);
                check("mrst_id", int'(o0_id), 0, 0);
            end
            if (e >= 6 && e <= 16 && o0_valid) nvalid++;
            if (e == 17) begin
                check("mrst_new_valid", int'(o0_valid), 1, 0);
                check("mrst_new_id", int'(o0_id), 99, 0);
                check("mrst_new_ang", $signed(o0_angle), 402, 3);
            end
            if (e == 18) check("mrst_after_valid", int'(o0_valid), 0, 0);
        end
        check("mrst_flushed", nvalid, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
